// File: rtl/prog_loader_if.sv
// Byte-stream input and dpram/core-control outputs of the program loader.
// The signal names carry the loader's point of view (_i into the loader, _o out of it).
interface prog_loader_if;
  logic        byte_valid_i;
  logic [7:0]  byte_i;
  logic        byte_ready_o;
  logic        ram_ce_o;
  logic        ram_we_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_data_o;
  logic        core_rst_o;
  logic        done_o;
  logic        err_o;

  // Loader side.
  modport slave (
    input  byte_valid_i, byte_i,
    output byte_ready_o, ram_ce_o, ram_we_o, ram_addr_o, ram_data_o,
           core_rst_o, done_o, err_o
  );

  // Byte source / observer side.
  modport master (
    output byte_valid_i, byte_i,
    input  byte_ready_o, ram_ce_o, ram_we_o, ram_addr_o, ram_data_o,
           core_rst_o, done_o, err_o
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: parses A5 | N (LE32) | 4N data bytes | XOR checksum from a
// valid/ready byte stream, writes each word to dpram and releases the core
// once the checksum matches.
module prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] MAX_WORDS = 32'h0008_0000
) (
  input  logic          clk_i,
  input  logic          rst_i,
  prog_loader_if.slave  bus
);

  localparam logic [7:0] MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    IDLE, LEN, DATA, WRITE, CSUM, DONE, ERR
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] len_q, len_d;    // word count being shifted in
  logic [31:0] word_q, word_d;  // data word being shifted in, also the write data
  logic [31:0] rem_q, rem_d;    // words still to be written
  logic [31:0] addr_q, addr_d;  // byte address of the next write
  logic [1:0]  cnt_q, cnt_d;    // byte position within the current 4-byte field
  logic [7:0]  csum_q, csum_d;  // running XOR of accepted data bytes

  logic        take;
  logic [31:0] len_shift;
  logic [31:0] word_shift;

  // A transfer needs both sides; ready itself is decoded from state only.
  assign take       = bus.byte_valid_i && bus.byte_ready_o;
  // Little-endian fields: each new byte enters at the top and earlier bytes move down.
  assign len_shift  = {bus.byte_i, len_q[31:8]};
  assign word_shift = {bus.byte_i, word_q[31:8]};

  // Outputs are pure decodes of the state register plus registered datapath values.
  assign bus.byte_ready_o = (state_q != WRITE) && (state_q != DONE);
  assign bus.ram_ce_o     = (state_q == WRITE);
  assign bus.ram_we_o     = (state_q == WRITE);
  assign bus.ram_addr_o   = addr_q;
  assign bus.ram_data_o   = word_q;
  assign bus.core_rst_o   = (state_q != DONE);
  assign bus.done_o       = (state_q == DONE);
  assign bus.err_o        = (state_q == ERR);

  // State and datapath registers, cleared asynchronously by rst_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      len_q   <= '0;
      word_q  <= '0;
      rem_q   <= '0;
      addr_q  <= BASE_ADDR;
      cnt_q   <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      word_q  <= word_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
    end
  end

  // Next-state and datapath update for the frame parser.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    word_d  = word_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;

    unique case (state_q)
      IDLE, ERR: begin
        // Only a magic byte starts (or retries) a frame; everything else is dropped.
        if (take && bus.byte_i == MAGIC) begin
          state_d = LEN;
          cnt_d   = '0;
          csum_d  = '0;
          addr_d  = BASE_ADDR;
        end
      end
      LEN: begin
        if (take) begin
          len_d = len_shift;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            rem_d = len_shift;
            if (len_shift > MAX_WORDS)   state_d = ERR;
            else if (len_shift == '0)    state_d = CSUM;
            else                         state_d = DATA;
          end
        end
      end
      DATA: begin
        if (take) begin
          word_d = word_shift;
          csum_d = csum_q ^ bus.byte_i;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        // The write itself is decoded from the state; here we step to the next word.
        addr_d  = addr_q + 32'd4;
        rem_d   = rem_q - 32'd1;
        state_d = (rem_q == 32'd1) ? CSUM : DATA;
      end
      CSUM: begin
        if (take) state_d = (bus.byte_i == csum_q) ? DONE : ERR;
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader. The reference model works at
// frame level: from the word list it predicts the write sequence (BASE+4i, word i),
// the XOR checksum and the final done/err outcome.
`timescale 1ns/1ps
module tb_prog_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] MAXW = 32'h0008_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  prog_loader_if bus_if ();

  prog_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] words[$];     // words of the frame under test
  logic [31:0] got_addr[$];  // observed dpram writes
  logic [31:0] got_data[$];
  int          ready_in_write = 0;
  int          ce_we_split    = 0;
  bit          use_gaps       = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Passive monitor, sampling between clock edges.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.ram_ce_o && bus_if.ram_we_o) begin
        got_addr.push_back(bus_if.ram_addr_o);
        got_data.push_back(bus_if.ram_data_o);
        if (bus_if.byte_ready_o) ready_in_write++;
      end
      if (bus_if.ram_ce_o != bus_if.ram_we_o) ce_we_split++;
    end
  end

  function automatic logic [7:0] xor_words();
    logic [7:0] c = 8'h00;
    foreach (words[i]) c ^= words[i][7:0] ^ words[i][15:8] ^ words[i][23:16] ^ words[i][31:24];
    return c;
  endfunction

  // Offer one byte and hold it until it is accepted (bounded wait).
  task automatic send_byte(input logic [7:0] b);
    int  guard;
    bit  rdy;
    if (use_gaps) begin
      int n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) begin
        bus_if.byte_valid_i = 1'b0;
        bus_if.byte_i       = 8'($urandom);
        @(negedge clk);
      end
    end
    bus_if.byte_valid_i = 1'b1;
    bus_if.byte_i       = b;
    guard = 0;
    do begin
      rdy = bus_if.byte_ready_o;
      @(posedge clk);
      @(negedge clk);
      guard++;
    end while (!rdy && guard < 20);
    if (!rdy) chk("byte_accept_timeout", 64'(guard), 64'd0);
  endtask

  task automatic send_header(input logic [31:0] n);
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8]);
  endtask

  // Full frame from 'words'; csum_flip != 0 corrupts the checksum byte.
  task automatic send_frame(input logic [7:0] csum_flip);
    send_header(32'(words.size()));
    foreach (words[i]) for (int j = 0; j < 4; j++) send_byte(words[i][8*j +: 8]);
    send_byte(xor_words() ^ csum_flip);
    if (!use_gaps) bus_if.byte_valid_i = 1'b0;
  endtask

  task automatic clear_obs();
    got_addr.delete();
    got_data.delete();
    ready_in_write = 0;
  endtask

  task automatic do_reset();
    bus_if.byte_valid_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_obs();
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwr"}, 64'(got_addr.size()), 64'(words.size()));
    for (int i = 0; i < words.size() && i < got_addr.size(); i++) begin
      chk({tag, "_addr"}, 64'(got_addr[i]), 64'(BASE + 32'(4 * i)));
      chk({tag, "_data"}, 64'(got_data[i]), 64'(words[i]));
    end
    chk({tag, "_rdy_in_wr"}, 64'(ready_in_write), 64'd0);
  endtask

  task automatic check_outcome(input string tag, input bit good);
    chk({tag, "_done"}, 64'(bus_if.done_o), 64'(good));
    chk({tag, "_err"}, 64'(bus_if.err_o), 64'(!good));
    chk({tag, "_core_rst"}, 64'(bus_if.core_rst_o), 64'(!good));
    chk({tag, "_ready"}, 64'(bus_if.byte_ready_o), 64'(!good));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, 64'(bus_if.byte_ready_o), 64'd1);
    chk({tag, "_ce"}, 64'(bus_if.ram_ce_o), 64'd0);
    chk({tag, "_we"}, 64'(bus_if.ram_we_o), 64'd0);
    chk({tag, "_addr"}, 64'(bus_if.ram_addr_o), 64'(BASE));
    chk({tag, "_data"}, 64'(bus_if.ram_data_o), 64'd0);
    chk({tag, "_core_rst"}, 64'(bus_if.core_rst_o), 64'd1);
    chk({tag, "_done"}, 64'(bus_if.done_o), 64'd0);
    chk({tag, "_err"}, 64'(bus_if.err_o), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.byte_valid_i = 1'b0;
    bus_if.byte_i       = 8'h00;
    @(negedge clk);
    check_reset_vals("reset");
    do_reset();

    // Good load of two words.
    words = '{32'h0000_0013, 32'h0000_006F};
    chk("model_csum", 64'(xor_words()), 64'h7C);
    send_frame(8'h00);
    check_writes("good");
    check_outcome("good", 1'b1);
    $display("good load: %0d writes, done=%0b", got_addr.size(), bus_if.done_o);

    // Bad checksum, then retry with a good frame straight from ERR.
    do_reset();
    send_frame(8'h7C);  // checksum byte becomes 00
    check_writes("badcs");
    check_outcome("badcs", 1'b0);
    send_byte(8'h3C);   // non-magic noise in ERR is discarded
    chk("badcs_noise_err", 64'(bus_if.err_o), 64'd1);
    clear_obs();
    send_frame(8'h00);
    check_writes("retry");
    check_outcome("retry", 1'b1);
    $display("bad checksum then retry: done=%0b", bus_if.done_o);

    // Zero length.
    do_reset();
    words.delete();
    send_frame(8'h00);
    check_writes("zero");
    check_outcome("zero", 1'b1);
    $display("zero length: %0d writes, done=%0b", got_addr.size(), bus_if.done_o);

    // Oversize, and the largest legal count is still accepted.
    do_reset();
    send_header(MAXW + 32'd1);
    chk("over_err", 64'(bus_if.err_o), 64'd1);
    chk("over_nwr", 64'(got_addr.size()), 64'd0);
    do_reset();
    send_header(MAXW);
    chk("maxw_err", 64'(bus_if.err_o), 64'd0);
    bus_if.byte_valid_i = 1'b0;
    $display("oversize: err after length, max count accepted");

    // Continuous valid with leading noise.
    do_reset();
    send_byte(8'h00);
    send_byte(8'hFF);
    words = '{32'hDEAD_BEEF, 32'h0123_4567, 32'hA5A5_A5A5};
    send_frame(8'h00);
    check_writes("bp");
    check_outcome("bp", 1'b1);
    $display("back-pressure with noise: %0d writes, done=%0b", got_addr.size(), bus_if.done_o);

    // Asynchronous reset out of DONE.
    rst = 1'b1;
    #1;
    check_reset_vals("async_from_done");
    rst = 1'b0;
    @(negedge clk);

    // Reset after three data bytes, then a full frame from BASE.
    clear_obs();
    send_header(32'd2);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    rst = 1'b1;
    #1;
    check_reset_vals("midreset");
    do_reset();
    words = '{32'hCAFE_F00D, 32'h8000_0001};
    send_frame(8'h00);
    check_writes("after_rst");
    check_outcome("after_rst", 1'b1);
    $display("reset mid-frame then reload: done=%0b", bus_if.done_o);

    // Randomized frames.
    for (int it = 0; it < 12; it++) begin
      logic [7:0] flip;
      bit         good;
      do_reset();
      use_gaps = ($urandom_range(0, 1) == 1);
      words.delete();
      for (int i = 0, n = $urandom_range(0, 5); i < n; i++) words.push_back($urandom);
      good = ($urandom_range(0, 3) != 0);
      flip = good ? 8'h00 : 8'($urandom_range(1, 255));
      send_frame(flip);
      bus_if.byte_valid_i = 1'b0;
      check_writes("rand");
      check_outcome("rand", good);
      $display("random frame %0d: N=%0d gaps=%0b good=%0b writes=%0d", it, words.size(), use_gaps, good, got_addr.size());
    end

    chk("ce_we_together", 64'(ce_we_split), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
